// File: rtl/mtm_alu_pkg.sv
// mtm_Alu serial link: shared frame types, FSM states, bit positions
// and the CRC3 reference function used by both link directions.
package mtm_alu_pkg;

    typedef enum logic {
        FT_DATA = 1'b0,
        FT_CTL  = 1'b1
    } frame_type_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TYPE,
        DATA,
        STOP
    } ser_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;
        logic [2:0]  err;
    } rsp_t;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVFL  = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam logic [2:0] LAST_FRM  = 3'd4;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    // x^3 + x + 1 without the implicit x^3 term
    localparam logic [2:0] CRC3_POLY = 3'b011;

    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1:0], 1'b0} ^ ({3{fb}} & CRC3_POLY);
        end
        return crc;
    endfunction

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 over the 37-bit {C, 1'b0, flags} message.
// Shared between the response transmitter and the checker side.
import mtm_alu_pkg::*;

module mtm_alu_crc3 (
    input  logic [36:0] msg,
    output logic [2:0]  crc
);

    assign crc = crc3_calc(msg);

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_Alu response transmitter: turns one captured ALU result into
// DATA/CTL serial frames on sout (start, type, 8 bits MSB first, stop).
import mtm_alu_pkg::*;

module mtm_alu_serializer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    input  logic [3:0]  rsp_flags,
    input  logic [2:0]  rsp_err,
    output logic        sout,
    output logic        busy
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    ser_state_t    state;
    ser_state_t    state_nxt;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] cyc_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [2:0]    frm_cnt;
    logic [2:0]    frm_nxt;

    rsp_t        cap;
    logic [2:0]  crc;
    logic        accept;
    logic        is_err;
    logic        bit_end;
    logic        last_frm;
    logic [7:0]  data_byte;
    logic [7:0]  ctl_byte;
    logic [7:0]  err_byte;
    logic [7:0]  tx_byte;
    frame_type_t tx_type;
    logic        sout_nxt;

    assign accept   = rsp_valid && rsp_ready;
    assign is_err   = |cap.err;
    assign bit_end  = (cyc_cnt == CYC_LAST);
    assign last_frm = is_err || (frm_cnt == LAST_FRM);

    assign rsp_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    mtm_alu_crc3 u_crc3 (
        .msg ({cap.data, 1'b0, cap.flags}),
        .crc (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap <= '0;
        end else if (accept) begin
            cap <= '{data: rsp_data, flags: rsp_flags, err: rsp_err};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            frm_cnt <= '0;
            sout    <= 1'b1;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            frm_cnt <= frm_nxt;
            sout    <= sout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        frm_nxt   = frm_cnt;
        if (state == IDLE) begin
            cyc_nxt = '0;
            bit_nxt = '0;
            frm_nxt = '0;
            if (accept) begin
                state_nxt = START;
            end
        end else if (!bit_end) begin
            cyc_nxt = cyc_cnt + 1'b1;
        end else begin
            cyc_nxt = '0;
            unique case (state)
                START: state_nxt = TYPE;
                TYPE: begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (last_frm) begin
                        state_nxt = IDLE;
                        frm_nxt   = '0;
                    end else begin
                        state_nxt = START;
                        frm_nxt   = frm_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign ctl_byte = {1'b0,
                       cap.flags[FLAG_CARRY], cap.flags[FLAG_OVFL],
                       cap.flags[FLAG_ZERO], cap.flags[FLAG_NEG],
                       crc};

    // Error code is sent twice plus even parity over the first seven bits
    assign err_byte = {1'b1,
                       cap.err[ERR_DATA], cap.err[ERR_CRC], cap.err[ERR_OP],
                       cap.err[ERR_DATA], cap.err[ERR_CRC], cap.err[ERR_OP],
                       ^{1'b1, cap.err, cap.err}};

    always_comb begin
        unique case (frm_nxt[1:0])
            2'd0:    data_byte = cap.data[31:24];
            2'd1:    data_byte = cap.data[23:16];
            2'd2:    data_byte = cap.data[15:8];
            default: data_byte = cap.data[7:0];
        endcase
    end

    always_comb begin
        tx_type = (is_err || frm_nxt == LAST_FRM) ? FT_CTL : FT_DATA;
        unique case (1'b1)
            is_err:                tx_byte = err_byte;
            (frm_nxt == LAST_FRM): tx_byte = ctl_byte;
            default:               tx_byte = data_byte;
        endcase
    end

    // sout is registered from the next state so each bit appears with it
    always_comb begin
        unique case (state_nxt)
            START:   sout_nxt = 1'b0;
            TYPE:    sout_nxt = tx_type;
            DATA:    sout_nxt = tx_byte[LAST_BIT - bit_nxt];
            default: sout_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: frame scoreboard on sout plus
// handshake, timing, reset and BIT_CYCLES=4 checks.
module tb_mtm_alu_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_data = '0;
    logic [3:0]  rsp_flags = '0;
    logic [2:0]  rsp_err = '0;
    logic        sout;
    logic        busy;

    logic        v4 = 1'b0;
    logic        r4;
    logic [31:0] d4 = '0;
    logic [3:0]  f4 = 4'b0010;
    logic [2:0]  e4 = '0;
    logic        s4;
    logic        b4;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];

    always #5 clk = ~clk;

    mtm_alu_serializer #(.BIT_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .sout      (sout),
        .busy      (busy)
    );

    mtm_alu_serializer #(.BIT_CYCLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (v4),
        .rsp_ready (r4),
        .rsp_data  (d4),
        .rsp_flags (f4),
        .rsp_err   (e4),
        .sout      (s4),
        .busy      (b4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] crc_model(input logic [31:0] c,
                                             input logic [3:0] f);
        logic [36:0] m;
        logic [2:0]  r;
        logic        fb;
        m = {c, 1'b0, f};
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ m[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    task automatic push_pkt(input logic [31:0] c, input logic [3:0] f,
                            input logic [2:0] e);
        if (e != 3'b000) begin
            sb.push_back({1'b1, 1'b1, e, e, ^{1'b1, e, e}});
        end else begin
            for (int k = 0; k < 4; k++)
                sb.push_back({1'b0, 8'(c >> (24 - 8 * k))});
            sb.push_back({1'b1, 1'b0, f, crc_model(c, f)});
        end
    endtask

    // frame decoder: start bit, type, 8 payload bits, stop bit
    int         nb = 0;
    logic [10:0] fr;
    logic [8:0]  exp_fr;
    always @(negedge clk) begin
        if (rst) begin
            nb = 0;
        end else if (nb == 0) begin
            if (sout === 1'b0) begin
                fr[10] = 1'b0;
                nb = 1;
            end
        end else begin
            fr[10 - nb] = sout;
            nb++;
            if (nb == 11) begin
                nb = 0;
                if (sb.size() == 0) begin
                    chk("frame_unexpected", 0, 1);
                end else begin
                    exp_fr = sb.pop_front();
                    chk("frame", {23'b0, fr[9:1]}, {23'b0, exp_fr});
                    chk("stop_bit", {31'b0, fr[0]}, 1);
                end
            end
        end
    end

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            n++;
            rsp_data  = $urandom;
            rsp_flags = 4'($urandom);
            rsp_err   = 3'($urandom);
            @(negedge clk);
        end
        chk("idle_bit", {busy, rsp_ready, sout}, 3'b011);
    endtask

    task automatic send(input logic [31:0] c, input logic [3:0] f,
                        input logic [2:0] e, input bit hold,
                        input int exp_len, output int waited);
        int n;
        rsp_data  = c;
        rsp_flags = f;
        rsp_err   = e;
        rsp_valid = 1'b1;
        waited = 0;
        while (!rsp_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_timeout", int'(waited < 2000), 1);
        @(posedge clk);
        #1;
        if (!hold) rsp_valid = 1'b0;
        chk("accept_latency", {rsp_ready, busy, sout}, 3'b010);
        count_busy(n);
        chk("busy_len", n, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int mis;
        logic exp_bits[55];
        logic [8:0] frames[5];

        repeat (2) @(negedge clk);
        chk("rst_state", {sout, rsp_ready, busy}, 3'b110);
        chk("rst_state4", {s4, r4, b4}, 3'b110);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_after_rst", {sout, rsp_ready, busy}, 3'b110);
        end

        // all-zero result: CTL payload 0x16
        for (int k = 0; k < 4; k++) sb.push_back(9'h000);
        sb.push_back(9'h116);
        send(32'h0000_0000, 4'b0010, 3'b000, 1'b0, 55, w);

        sb.push_back(9'h193);
        send(32'hFFFF_FFFF, 4'b1111, 3'b001, 1'b0, 11, w);
        sb.push_back(9'h1A5);
        send(32'h1234_5678, 4'b1010, 3'b010, 1'b0, 11, w);
        sb.push_back(9'h1C9);
        send(32'hA5A5_A5A5, 4'b0101, 3'b100, 1'b0, 11, w);

        push_pkt(32'h8000_0000, 4'b1101, 3'b000);
        send(32'h8000_0000, 4'b1101, 3'b000, 1'b0, 55, w);

        // rsp_valid held high across three responses
        push_pkt(32'h1234_5678, 4'b0101, 3'b000);
        send(32'h1234_5678, 4'b0101, 3'b000, 1'b1, 55, w);
        push_pkt(32'hDEAD_BEEF, 4'b1000, 3'b000);
        send(32'hDEAD_BEEF, 4'b1000, 3'b000, 1'b1, 55, w);
        chk("b2b_gap2", w, 0);
        push_pkt(32'hCAFE_F00D, 4'b0001, 3'b011);
        send(32'hCAFE_F00D, 4'b0001, 3'b011, 1'b0, 11, w);
        chk("b2b_gap3", w, 0);

        // reset during DATA bit 4 of the second frame
        push_pkt(32'h0000_0000, 4'b0000, 3'b000);
        rsp_data  = 32'h0000_0000;
        rsp_flags = 4'b0000;
        rsp_err   = 3'b000;
        rsp_valid = 1'b1;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("pre_rst_sout", {31'b0, sout}, 0);
        rst = 1'b1;
        #1;
        chk("rst_async", {sout, rsp_ready, busy}, 3'b110);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("no_resume", {sout, rsp_ready, busy}, 3'b110);
        end

        push_pkt(32'h0F1E_2D3C, 4'b0110, 3'b000);
        send(32'h0F1E_2D3C, 4'b0110, 3'b000, 1'b0, 55, w);

        // BIT_CYCLES=4 build of the all-zero case
        for (int k = 0; k < 4; k++) frames[k] = 9'h000;
        frames[4] = 9'h116;
        for (int k = 0; k < 5; k++) begin
            exp_bits[11 * k] = 1'b0;
            for (int b = 0; b < 9; b++)
                exp_bits[11 * k + 1 + b] = frames[k][8 - b];
            exp_bits[11 * k + 10] = 1'b1;
        end
        chk("bc4_ready", {31'b0, r4}, 1);
        v4 = 1'b1;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        mis = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (s4 !== exp_bits[i / 4] || b4 !== 1'b1) mis++;
        end
        chk("bc4_bits", mis, 0);
        @(negedge clk);
        chk("bc4_end", {b4, r4, s4}, 3'b011);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
